param_reg_file: RTL

PARAM_REG_FILE -- requirements
Module: param_reg_file

---
 rtl/param_reg_file.sv | 120 ++++++++++++
 1 files changed

// File: rtl/param_reg_file.sv
// Parameterised register file: r0 hardwired to zero, optional write
// forwarding, and a sequential clear engine that sweeps r1..rDEPTH-1.
module param_reg_file #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 4,
  parameter bit BYPASS = 1'b1
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [$clog2(DEPTH)-1:0] rr1,
  input  logic [$clog2(DEPTH)-1:0] rr2,
  input  logic [$clog2(DEPTH)-1:0] wr,
  input  logic [WIDTH-1:0]         wd,
  input  logic                     regwrite,
  input  logic                     clr_req,
  output logic [WIDTH-1:0]         rd1,
  output logic [WIDTH-1:0]         rd2,
  output logic                     busy,
  output logic                     clr_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [AW-1:0]  idx;
  logic [AW-1:0]  idx_nx;
  logic           clr_we;
  logic           we;
  logic           fwd1;
  logic           fwd2;
  logic [WIDTH-1:0] regs [DEPTH];

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    busy     = 1'b0;
    clr_done = 1'b0;
    clr_we   = 1'b0;
    unique case (state)
      IDLE: begin
        if (clr_req) begin
          state_nx = CLEAR;
          idx_nx   = AW'(1);
        end
      end
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        // Stop on the last index rather than relying on wrap-around.
        if (idx == LAST) begin
          state_nx = DONE;
        end else begin
          idx_nx = idx + AW'(1);
        end
      end
      DONE: begin
        clr_done = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  assign we = regwrite && !busy && (wr != '0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (we) begin
        regs[wr] <= wd;
      end
      if (clr_we) begin
        regs[idx] <= '0;
      end
    end
  end

  assign fwd1 = BYPASS && we && (rr1 == wr);
  assign fwd2 = BYPASS && we && (rr2 == wr);

  // Forced to zero under reset so a pending bypass cannot leak out.
  always_comb begin
    rd1 = regs[rr1];
    rd2 = regs[rr2];
    if (fwd1) begin
      rd1 = wd;
    end
    if (fwd2) begin
      rd2 = wd;
    end
    if (!resetn) begin
      rd1 = '0;
      rd2 = '0;
    end
  end

endmodule
